display_mux_n: RTL and testbench
================================

DISPLAY_MUX_N -- requirements
Module: display_mux_n

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NUM_DIGITS, 4, number of multiplexed hex digits; legal range 1..8.
- DIV_BITS, 18, refresh divider width; each digit is lit for 2^DIV_BITS clk cycles; minimum 1.

REQ-002 Ports SHALL be, one per line: name direction width meaning.
- clk  input  1  single clock; all state updates on its rising edge.
- clr  input  1  reset; synchronous and active-high.
- data_in  input  4*NUM_DIGITS  hex nibbles; digit k is data_in[4k+3:4k], and digit 0 is rightmost.
- dp_in  input  NUM_DIGITS  per-digit decimal point request; 1 = lit.
- load  input  1  single-cycle request to capture data_in and dp_in.
- busy  output  1  high while captured data waits to be applied.
- seg  output  7  segments g..a, active-low.
- dp  output  1  decimal point, active-low.
- an  output  NUM_DIGITS  digit enables, active-low, one-cold.
- frame_start  output  1  one-cycle pulse when the digit index wraps to 0.

Function
REQ-003 The divider counter SHALL increment every cycle, wrapping modulo 2^DIV_BITS; tick is asserted in the cycle where the counter equals all-ones.
REQ-004 On tick, the digit index SHALL advance by 1 and wrap from NUM_DIGITS-1 to 0.
REQ-005 The index SHALL stay at 0 when NUM_DIGITS = 1.
REQ-006 seg, dp and an SHALL be registered and reflect the current index one cycle after the index changes.
REQ-007 an SHALL drive 0 only on bit [index].
REQ-008 seg SHALL carry the hex pattern of the shadow nibble at that index, using these values: 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011, C = 1000110, d = 0100001, E = 0000110, F = 0001110. Blank is 1111111.
REQ-009 dp SHALL be the inverse of the shadow dp bit at the index.
REQ-010 A load sampled high SHALL copy data_in and dp_in into the staging register and set pending; busy equals pending.
REQ-011 A load sampled while pending SHALL overwrite staging (latest wins), and pending SHALL stay set.
REQ-012 On the tick that wraps the index to 0, the shadow SHALL take the staging value when pending, and pending SHALL clear. The new data therefore takes effect only on a frame boundary, so no frame ever shows mixed data.
REQ-013 If load coincides with the apply tick, the shadow SHALL take the old staging value, staging SHALL take the new data, and pending SHALL stay 1.
REQ-014 frame_start SHALL be asserted in the cycle after the wrap tick, aligned with an = ...1110.
REQ-015 Changes on data_in or dp_in without load SHALL have no effect on the outputs.

Reset
REQ-016 While clr is high at a clk edge, the block SHALL load these values on that edge, overriding load and tick:
- divider 0 and index 0;
- staging and shadow 0, pending 0;
- seg 1111111, dp 1, an all-ones, busy 0, frame_start 0.
REQ-017 clr asserted mid-frame or mid-pending SHALL discard the pending data.
REQ-018 In the cycle after clr deasserts, an SHALL equal ...1110 and seg SHALL show the shadow digit 0 value (0 after reset).

Configuration
REQ-019 With the macro DISPLAY_MUX_LEADING_ZERO_BLANK_EN defined, leading-zero blanking SHALL apply:
- a digit k > 0 SHALL display blank seg when shadow digits NUM_DIGITS-1..k are all zero;
- digit 0 SHALL never blank;
- dp SHALL be unaffected by blanking.
REQ-020 Without the macro, all digits SHALL always show their hex pattern, and no blanking logic SHALL be present.

Structure
REQ-021 A shared package display_pkg SHALL hold:
- the 16 segment-pattern constants and the blank constant;
- the maximum digit count (8);
- the digit-index width function.
REQ-022 The hex-to-segment lookup SHALL be the sub-module seg7_decode, with a 4-bit nibble and a blank flag in and 7-bit seg out, purely combinational; display_mux_n instantiates it once.

Verification
All scenarios run with DIV_BITS=2 and NUM_DIGITS=4, giving a 4-cycle digit dwell and a 16-cycle frame.
REQ-023 Reset, no load: an SHALL cycle 1110, 1101, 1011, 0111, each held 4 cycles; seg SHALL stay 1000000 and dp SHALL stay 1.
REQ-024 load with data_in = 16'h1A3F and dp_in = 4'b0100 mid-frame: busy SHALL go 1 and the display SHALL be unchanged until frame_start. The next frame SHALL show:
- seg 0001110 / 0110000 / 0001000 / 1111001;
- dp 0 only on digit 2.
busy SHALL go 0 with the apply.
REQ-025 load 16'h1111 and then 16'h2222 in the same frame: the next frame SHALL show only 2s (0100100).
REQ-026 load 16'h3333 in the same cycle as the apply of 16'h1111: the next frame SHALL show 1s and busy SHALL stay 1; the following frame SHALL show 3s and busy SHALL then be 0.
REQ-027 clr pulsed mid-frame with data pending: the next cycle SHALL show the REQ-016 values, and the following cycle SHALL show an = 1110 with busy = 0.
REQ-028 With DISPLAY_MUX_LEADING_ZERO_BLANK_EN defined:
- loading 16'h0050 SHALL give digits 3 and 2 blank, digit 1 = 0010010 and digit 0 = 1000000;
- loading 16'h0000 SHALL give only digit 0 lit (1000000).

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants for the multiplexed hex display: segment patterns (g..a, active-low),
// the digit-count ceiling and the digit-index width helper.
package display_pkg;

  localparam int MAX_DIGITS = 8;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // A single-digit display still needs a 1-bit index register.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex-nibble to 7-segment (g..a, active-low) decoder with a blank override.
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    if (!i_blank) begin
      case (i_nibble)
        4'h0: o_seg = SEG_0;
        4'h1: o_seg = SEG_1;
        4'h2: o_seg = SEG_2;
        4'h3: o_seg = SEG_3;
        4'h4: o_seg = SEG_4;
        4'h5: o_seg = SEG_5;
        4'h6: o_seg = SEG_6;
        4'h7: o_seg = SEG_7;
        4'h8: o_seg = SEG_8;
        4'h9: o_seg = SEG_9;
        4'hA: o_seg = SEG_A;
        4'hB: o_seg = SEG_B;
        4'hC: o_seg = SEG_C;
        4'hD: o_seg = SEG_D;
        4'hE: o_seg = SEG_E;
        4'hF: o_seg = SEG_F;
      endcase
    end
  end

endmodule

// File: rtl/display_mux_n.sv
// N-digit multiplexed hex display with frame-synchronous double-buffered data load.
// Optional leading-zero blanking is built when DISPLAY_MUX_LEADING_ZERO_BLANK_EN is defined.
module display_mux_n
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIV_BITS   = 18
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  output logic                    busy,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int IDX_W = idx_width(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic [DIV_BITS-1:0]     r_div;
  logic [IDX_W-1:0]        r_idx;
  logic [4*NUM_DIGITS-1:0] r_staging;
  logic [NUM_DIGITS-1:0]   r_dp_staging;
  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic [NUM_DIGITS-1:0]   r_dp_shadow;
  logic                    r_pending;
  logic                    r_wrap_q;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_an;
  logic                    r_frame_start;

  logic                    w_tick;
  logic                    w_wrap;
  logic [3:0]              w_nibble;
  logic                    w_dp_bit;
  logic [NUM_DIGITS-1:0]   w_an_next;
  logic                    w_blank;
  logic [6:0]              w_seg;

  assign w_tick = &r_div;
  assign w_wrap = w_tick && (r_idx == LAST_IDX);

  always_comb begin
    w_nibble  = 4'h0;
    w_dp_bit  = 1'b0;
    w_an_next = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_nibble     = r_shadow[4*k +: 4];
        w_dp_bit     = r_dp_shadow[k];
        w_an_next[k] = 1'b0;
      end
    end
  end

`ifdef DISPLAY_MUX_LEADING_ZERO_BLANK_EN
  // w_lz[k] is set when shadow digits NUM_DIGITS-1 down to k are all zero.
  logic [NUM_DIGITS-1:0] w_lz;
  logic                  w_run;

  always_comb begin
    w_lz    = '0;
    w_run   = 1'b1;
    w_blank = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      w_run   = w_run && (r_shadow[4*k +: 4] == 4'h0);
      w_lz[k] = w_run;
    end
    for (int k = 1; k < NUM_DIGITS; k++) begin
      if (r_idx == IDX_W'(k)) w_blank = w_lz[k];
    end
  end
`else
  assign w_blank = 1'b0;
`endif

  seg7_decode u_seg7_decode (
    .i_nibble (w_nibble),
    .i_blank  (w_blank),
    .o_seg    (w_seg)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      r_div         <= '0;
      r_idx         <= '0;
      r_staging     <= '0;
      r_dp_staging  <= '0;
      r_shadow      <= '0;
      r_dp_shadow   <= '0;
      r_pending     <= 1'b0;
      r_wrap_q      <= 1'b0;
      r_seg         <= SEG_BLANK;
      r_dp          <= 1'b1;
      r_an          <= '1;
      r_frame_start <= 1'b0;
    end else begin
      r_div <= r_div + DIV_BITS'(1);
      if (w_tick) r_idx <= w_wrap ? '0 : r_idx + IDX_W'(1);

      // Shadow takes the staging value seen before this edge, so a load on the
      // apply tick lands in staging and stays pending for the next frame.
      if (w_wrap && r_pending) begin
        r_shadow    <= r_staging;
        r_dp_shadow <= r_dp_staging;
      end
      if (load) begin
        r_staging    <= data_in;
        r_dp_staging <= dp_in;
        r_pending    <= 1'b1;
      end else if (w_wrap) begin
        r_pending <= 1'b0;
      end

      // Outputs lag the index by one cycle; frame_start is delayed to match an.
      r_wrap_q      <= w_wrap;
      r_frame_start <= r_wrap_q;
      r_an          <= w_an_next;
      r_seg         <= w_seg;
      r_dp          <= ~w_dp_bit;
    end
  end

  assign busy        = r_pending;
  assign seg         = r_seg;
  assign dp          = r_dp;
  assign an          = r_an;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_display_mux_n.sv
// Directed self-checking bench for display_mux_n at NUM_DIGITS=4, DIV_BITS=2 (16-cycle frame).
module tb_display_mux_n;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] SA = 7'b0001000;
  localparam logic [6:0] SF = 7'b0001110;
  localparam logic [6:0] SB = 7'b1111111;

  logic        clk = 1'b0;
  logic        clr;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        busy;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_start;

  int checks = 0;
  int errors = 0;

  display_mux_n #(.NUM_DIGITS(4), .DIV_BITS(2)) dut (
    .clk         (clk),
    .clr         (clr),
    .data_in     (data_in),
    .dp_in       (dp_in),
    .load        (load),
    .busy        (busy),
    .seg         (seg),
    .dp          (dp),
    .an          (an),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load(input logic [15:0] d, input logic [3:0] p);
    data_in = d;
    dp_in   = p;
    load    = 1'b1;
    step();
    load    = 1'b0;
  endtask

  task automatic wait_frame(input string tag);
    int n;
    n = 0;
    step();
    while (frame_start !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL %s frame_start timeout got %b want 1", tag, frame_start);
    end
  endtask

  // Called in the frame_start cycle; checks all 16 cycles of the frame.
  task automatic check_frame(input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3,
                             input logic [3:0] dpm, input logic exp_busy,
                             input string tag);
    logic [6:0] es[4];
    logic [3:0] ean;
    logic       efs;
    int         d;
    es[0] = s0; es[1] = s1; es[2] = s2; es[3] = s3;
    checks++;
    if (busy !== exp_busy) begin
      errors++;
      $display("FAIL %s busy at frame start got %b want %b", tag, busy, exp_busy);
    end
    for (int c = 0; c < 16; c++) begin
      if (c > 0) step();
      d      = c / 4;
      ean    = 4'b1111;
      ean[d] = 1'b0;
      efs    = (c == 0);
      checks++;
      if (an !== ean) begin
        errors++;
        $display("FAIL %s an c=%0d got %b want %b", tag, c, an, ean);
      end
      checks++;
      if (seg !== es[d]) begin
        errors++;
        $display("FAIL %s seg c=%0d got %b want %b", tag, c, seg, es[d]);
      end
      checks++;
      if (dp !== ~dpm[d]) begin
        errors++;
        $display("FAIL %s dp c=%0d got %b want %b", tag, c, dp, ~dpm[d]);
      end
      checks++;
      if (frame_start !== efs) begin
        errors++;
        $display("FAIL %s frame_start c=%0d got %b want %b", tag, c, frame_start, efs);
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({seg, dp, an, busy, frame_start} !== {7'b1111111, 1'b1, 4'b1111, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values got seg=%b dp=%b an=%b busy=%b fs=%b want 1111111 1 1111 0 0",
               seg, dp, an, busy, frame_start);
    end
    clr = 1'b0;
    step();
    checks++;
    if ({an, seg, dp, busy} !== {4'b1110, S0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL post_reset got an=%b seg=%b dp=%b busy=%b want 1110 1000000 1 0",
               an, seg, dp, busy);
    end
    wait_frame("idle");
    check_frame(S0, S0, S0, S0, 4'b0000, 1'b0, "idle");
  endtask

  task automatic test_load_apply();
    int n;
    wait_frame("load_sync");
    repeat (4) step();
    pulse_load(16'h1A3F, 4'b0100);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL load_busy got %b want 1", busy);
    end
    data_in = 16'hFFFF;
    dp_in   = 4'b1111;
    n = 0;
    step();
    while (frame_start !== 1'b1 && n < 40) begin
      checks++;
      if (seg !== S0 || dp !== 1'b1) begin
        errors++;
        $display("FAIL load_unchanged got seg=%b dp=%b want 1000000 1", seg, dp);
      end
      step();
      n++;
    end
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL load_apply frame_start timeout got %b want 1", frame_start);
    end
    check_frame(SF, S3, SA, S1, 4'b0100, 1'b0, "load_apply");
  endtask

  task automatic test_latest_wins();
    wait_frame("latest_sync");
    repeat (2) step();
    pulse_load(16'h1111, 4'b0000);
    step();
    pulse_load(16'h2222, 4'b0000);
    wait_frame("latest");
    check_frame(S2, S2, S2, S2, 4'b0000, 1'b0, "latest");
  endtask

  task automatic test_load_at_apply();
    wait_frame("coincide_sync");
    pulse_load(16'h1111, 4'b0000);
    repeat (13) step();
    pulse_load(16'h3333, 4'b0000);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL coincide_busy got %b want 1", busy);
    end
    step();
    check_frame(S1, S1, S1, S1, 4'b0000, 1'b1, "coincide_old");
    wait_frame("coincide_new");
    check_frame(S3, S3, S3, S3, 4'b0000, 1'b0, "coincide_new");
  endtask

  task automatic test_clr_pending();
    wait_frame("clr_sync");
    repeat (3) step();
    pulse_load(16'h5555, 4'b1111);
    step();
    clr = 1'b1;
    step();
    checks++;
    if ({seg, dp, an, busy, frame_start} !== {7'b1111111, 1'b1, 4'b1111, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL clr_values got seg=%b dp=%b an=%b busy=%b fs=%b want 1111111 1 1111 0 0",
               seg, dp, an, busy, frame_start);
    end
    clr = 1'b0;
    step();
    checks++;
    if ({an, busy} !== {4'b1110, 1'b0}) begin
      errors++;
      $display("FAIL clr_release got an=%b busy=%b want 1110 0", an, busy);
    end
    wait_frame("clr_discard");
    check_frame(S0, S0, S0, S0, 4'b0000, 1'b0, "clr_discard");
  endtask

`ifdef DISPLAY_MUX_LEADING_ZERO_BLANK_EN
  task automatic test_blank();
    pulse_load(16'h0050, 4'b0000);
    wait_frame("blank_0050");
    check_frame(S0, S5, SB, SB, 4'b0000, 1'b0, "blank_0050");
    pulse_load(16'h0000, 4'b0000);
    wait_frame("blank_0000");
    check_frame(S0, SB, SB, SB, 4'b0000, 1'b0, "blank_0000");
  endtask
`endif

  initial begin
    clr     = 1'b1;
    load    = 1'b0;
    data_in = 16'h0000;
    dp_in   = 4'b0000;
    step();
    step();
    test_reset();
    test_load_apply();
    test_latest_wins();
    test_load_at_apply();
    test_clr_pending();
`ifdef DISPLAY_MUX_LEADING_ZERO_BLANK_EN
    test_blank();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
